// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: scheduler states, reset divisor
// and the baud-divisor width derived from the byte width.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2
  } sched_state_e;

  localparam int DATA_WIDTH_DEF   = 8;
  localparam int BAUD_DIV_RST_DEF = 868;  // 100 MHz / 115200

  function automatic int baud_w_of(input int data_width);
    return 2 * data_width + 1;
  endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational rotate-priority picker: first set bit of valid_i scanning
// upward from ptr_i with wrap at NUM_REQ.
module uart_rr_pick #(
  parameter int NUM_REQ = 4,
  localparam int IDX_W  = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic               any_o,
  output logic [IDX_W-1:0]   win_o
);

  localparam int J_W = IDX_W + 1;

  logic [J_W-1:0] j;

  always_comb begin
    any_o = 1'b0;
    win_o = '0;
    j     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = {1'b0, ptr_i} + J_W'(k);
      if (j >= J_W'(NUM_REQ)) j = j - J_W'(NUM_REQ);
      if (!any_o && valid_i[j[IDX_W-1:0]]) begin
        any_o = 1'b1;
        win_o = j[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one uart_tx between NUM_REQ byte producers,
// with packet locking so multi-byte records stay contiguous on the line.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int NUM_REQ      = 4,
  parameter int BAUD_W       = baud_w_of(DATA_WIDTH),
  parameter int BAUD_DIV_RST = BAUD_DIV_RST_DEF,
  parameter int LOCK_TO      = 4096,
  localparam int IDX_W       = $clog2(NUM_REQ)
) (
  input  logic                          clk_i_sched,
  input  logic                          rst_i_sched,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]            req_last_i,
  output logic [NUM_REQ-1:0]            req_ack_o,
  input  logic [BAUD_W-1:0]             cfg_baud_div_i,
  output logic                          tx_start_o,
  output logic [DATA_WIDTH-1:0]         tx_data_o,
  output logic [BAUD_W-1:0]             baud_div_o,
  input  logic                          tx_active_i,
  input  logic                          tx_done_i,
  output logic [IDX_W-1:0]              grant_o,
  output logic                          busy_o,
  output logic                          lock_err_o,
  output logic [1:0]                    state_o
);

  localparam int TO_W = (LOCK_TO > 2) ? $clog2(LOCK_TO) : 1;

  // Handshake: a requester holds req_valid_i/data/last stable until it sees
  // a one-cycle req_ack_o; the ack means the byte has been captured.

  sched_state_e              state_q, state_d;
  logic [DATA_WIDTH-1:0]     data_q, data_d;
  logic [NUM_REQ-1:0]        ack_q, ack_d;
  logic                      start_q, start_d;
  logic [IDX_W-1:0]          grant_q, grant_d;
  logic                      busy_q, busy_d;
  logic                      last_q, last_d;
  logic                      lock_q, lock_d;
  logic [IDX_W-1:0]          lock_idx_q, lock_idx_d;
  logic [IDX_W-1:0]          rr_ptr_q, rr_ptr_d;
  logic [TO_W-1:0]           to_cnt_q, to_cnt_d;
  logic                      lock_err_q, lock_err_d;
  logic [BAUD_W-1:0]         baud_q, baud_d;

  logic [NUM_REQ-1:0]        elig;
  logic                      any;
  logic [IDX_W-1:0]          win;

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] x);
    return (x == IDX_W'(NUM_REQ - 1)) ? '0 : x + 1'b1;
  endfunction

  // While locked only the lock owner may compete.
  assign elig = lock_q ? (req_valid_i & (NUM_REQ'(1) << lock_idx_q)) : req_valid_i;

  uart_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .valid_i (elig),
    .ptr_i   (rr_ptr_q),
    .any_o   (any),
    .win_o   (win)
  );

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    ack_d      = '0;
    start_d    = 1'b0;
    grant_d    = grant_q;
    busy_d     = busy_q;
    last_d     = last_q;
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    rr_ptr_d   = rr_ptr_q;
    to_cnt_d   = to_cnt_q;
    lock_err_d = 1'b0;
    baud_d     = baud_q;
    case (state_q)
      IDLE: begin
        if (!lock_q) baud_d = cfg_baud_div_i;
        if (!tx_active_i && any) begin
          state_d  = SEND;
          data_d   = req_data_i[int'(win)*DATA_WIDTH +: DATA_WIDTH];
          ack_d    = NUM_REQ'(1) << win;
          start_d  = 1'b1;
          grant_d  = win;
          busy_d   = 1'b1;
          last_d   = req_last_i[win];
          to_cnt_d = '0;
        end else if (lock_q && !req_valid_i[lock_idx_q]) begin
          if (to_cnt_q == TO_W'(LOCK_TO - 1)) begin
            lock_d     = 1'b0;
            rr_ptr_d   = wrap_inc(lock_idx_q);
            lock_err_d = 1'b1;
            to_cnt_d   = '0;
          end else begin
            to_cnt_d = to_cnt_q + 1'b1;
          end
        end
      end
      SEND: state_d = WAIT;
      WAIT: begin
        if (tx_done_i) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          if (last_q) begin
            lock_d   = 1'b0;
            rr_ptr_d = wrap_inc(grant_q);
          end else begin
            lock_d     = 1'b1;
            lock_idx_d = grant_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i_sched) begin
    if (rst_i_sched) begin
      state_q    <= IDLE;
      data_q     <= '0;
      ack_q      <= '0;
      start_q    <= 1'b0;
      grant_q    <= '0;
      busy_q     <= 1'b0;
      last_q     <= 1'b0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      rr_ptr_q   <= '0;
      to_cnt_q   <= '0;
      lock_err_q <= 1'b0;
      baud_q     <= BAUD_W'(BAUD_DIV_RST);
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      ack_q      <= ack_d;
      start_q    <= start_d;
      grant_q    <= grant_d;
      busy_q     <= busy_d;
      last_q     <= last_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      rr_ptr_q   <= rr_ptr_d;
      to_cnt_q   <= to_cnt_d;
      lock_err_q <= lock_err_d;
      baud_q     <= baud_d;
    end
  end

  assign req_ack_o  = ack_q;
  assign tx_start_o = start_q;
  assign tx_data_o  = data_q;
  assign baud_div_o = baud_q;
  assign grant_o    = grant_q;
  assign busy_o     = busy_q;
  assign lock_err_o = lock_err_q;
  assign state_o    = state_q;

endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Round-robin transmit scheduler that shares one `uart_tx` serializer between `NUM_REQ` byte producers in the UART image-processing path. It accepts bytes over a valid/ack handshake and drives `tx_start`, data and baud divisor into `uart_tx`. It waits for `done_o_tx` before launching the next byte. Packet locking keeps multi-byte records, such as pixel rows and headers, contiguous on the line.

## Interface
- `DATA_WIDTH`, 8: byte width; must match `uart_tx`.
- `NUM_REQ`, 4: number of requesters (2..8).
- `BAUD_W`, `2*DATA_WIDTH+1`: baud divisor width; matches `uart_tx` `baud_div_i_tx`.
- `BAUD_DIV_RST`, 868: divisor after reset (100 MHz / 115200).
- `LOCK_TO`, 4096: idle cycles allowed on a locked requester before the lock is broken.
- `clk_i_sched`  in  1  clock; one clock domain.
- `rst_i_sched`  in  1  synchronous, active-high reset.
- `req_valid_i`  in  NUM_REQ  byte available per requester; held until ack.
- `req_data_i`  in  NUM_REQ*DATA_WIDTH  flattened bytes; requester i at `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `req_last_i`  in  NUM_REQ  byte is the final byte of its packet.
- `req_ack_o`  out  NUM_REQ  one-cycle pulse: byte captured.
- `cfg_baud_div_i`  in  BAUD_W  requested divisor.
- `tx_start_o`  out  1  to `uart_tx` `tx_start`.
- `tx_data_o`  out  DATA_WIDTH  to `data_i_tx`.
- `baud_div_o`  out  BAUD_W  to `baud_div_i_tx`.
- `tx_active_i`  in  1  from `active_o_tx`.
- `tx_done_i`  in  1  from `done_o_tx`; one-cycle pulse.
- `grant_o`  out  $clog2(NUM_REQ)  index of the current/last granted requester.
- `busy_o`  out  1  byte in flight.
- `lock_err_o`  out  1  one-cycle pulse on lock timeout.

## Operation
- States:
  - IDLE: arbitrate.
  - SEND: `tx_start_o` asserted.
  - WAIT: wait for `tx_done_i`.
- IDLE → SEND requires all of the following:
  - `tx_active_i==0`;
  - at least one eligible valid.
- Eligibility depends on the lock:
  - Unlocked: all valids are eligible. The winner is the first valid found scanning from `rr_ptr` upward, with modulo wrap.
  - Locked: only `lock_idx` is eligible.
- On the IDLE→SEND edge:
  - `tx_data_o` ← winner byte;
  - `req_ack_o[w]` ← 1;
  - `tx_start_o` ← 1;
  - `grant_o` ← w;
  - `busy_o` ← 1;
  - `last_q` ← `req_last_i[w]`.
- SEND → WAIT unconditionally; `tx_start_o` and `req_ack_o` clear.
- On WAIT with `tx_done_i` → IDLE, and `busy_o` ← 0. Then:
  - If `last_q`: clear the lock and set `rr_ptr` ← w+1 (wrap at NUM_REQ).
  - Otherwise: lock ← 1 and `lock_idx` ← w.
- Lock timeout:
  - While locked in IDLE with `req_valid_i[lock_idx]==0`, the timeout counter increments.
  - At `LOCK_TO-1`, the lock is cleared, `rr_ptr` ← `lock_idx`+1 and `lock_err_o` pulses.
  - The counter resets on any launch.
- `baud_div_o` ← `cfg_baud_div_i` only in IDLE while unlocked. A divisor is never changed mid-byte or mid-packet.
- Unselected requesters are never acked. Their valid and data are ignored.
- `req_last_i` on a non-granted requester has no effect.

## Timing
- Reset values:
  - `tx_start_o`=0, `tx_data_o`=0, `req_ack_o`=0, `grant_o`=0, `busy_o`=0, `lock_err_o`=0;
  - `baud_div_o`=`BAUD_DIV_RST`;
  - `rr_ptr`=0, lock cleared, state IDLE.
- Launch timing:
  - Valid seen in IDLE at cycle T gives `tx_start_o`=1 and ack=1 in cycle T+1 only.
  - `uart_tx` samples start at the end of T+1.
- Turnaround:
  - `tx_done_i` at cycle D puts the scheduler in IDLE at D+1.
  - The next `tx_start_o` comes at D+2 at the earliest.
  - Minimum byte period = `uart_tx` frame + 2 cycles.
- Simultaneous events:
  - `tx_done_i` seen outside WAIT is ignored.
  - A lock timeout and a valid arriving in the same cycle: the valid wins and the byte launches.
- Reset mid-operation:
  - Returns to IDLE and drops the in-flight byte; no ack replay.
  - The next launch waits for `tx_active_i==0`, so a serializer still finishing a frame is never restarted.

## Structure
- Shared package `uart_pkg`:
  - state localparams IDLE/SEND/WAIT;
  - default `BAUD_DIV_RST`;
  - `BAUD_W` derivation.
- Sub-module `uart_rr_pick`: combinational rotate-priority picker.
  - Inputs: valid vector, `rr_ptr`.
  - Outputs: `any`, winner index.
- Sequential logic stays in `uart_tx_sched`.

## Test plan
- **Single byte:** `req_valid_i`=0001, data 0xA5, last=1 → `tx_start_o` one cycle after; `tx_data_o`=0xA5; `req_ack_o`=0001 for 1 cycle; next launch ≥2 cycles after `tx_done_i`.
- **Fairness:** all 4 requesters hold valid with last=1 → grants 0,1,2,3,0 in order; `rr_ptr` wraps 3→0.
- **Packet lock:** req1 sends 3 bytes (last on the third) while req0/req2 are valid → all 3 bytes of req1 go consecutively, then req2 is granted.
- **Lock timeout:** `LOCK_TO`=16; req1 sends last=0 then drops valid → `lock_err_o` pulses after 16 idle cycles; req2 is granted next.
- **Baud and reset:**
  - `cfg_baud_div_i` changed mid-packet → `baud_div_o` updates only after the last byte's done.
  - Reset during WAIT → all outputs return to reset values; no start is issued while `tx_active_i`=1.
